// File: rtl/route_select_pkg.sv
// Shared types and helpers for the route_select decision stage.
package route_select_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // Encoded port index width; a floor of 1 keeps degenerate widths legal.
    function automatic int idx_width(input int dir_w);
        return (dir_w > 1) ? $clog2(dir_w) : 1;
    endfunction

endpackage

// File: rtl/route_select_lsb_find.sv
// Combinational lowest-set-bit finder: returns presence, index and the mask
// with that bit cleared.
module lsb_find
    import route_select_pkg::*;
#(
    parameter int DIR_W = 4,
    localparam int IDX_W = idx_width(DIR_W)
) (
    input  logic [DIR_W-1:0] mask,
    output logic             found,
    output logic [IDX_W-1:0] idx,
    output logic [DIR_W-1:0] residual
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Scan downwards so the lowest set bit wins the final assignment.
        for (int i = DIR_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end
        end
    end

    assign residual = mask & (mask - DIR_W'(1));

endmodule

// File: rtl/route_select.sv
// Route-decision stage: turns a direction mask into one (unicast) or a
// sequence of (multicast) registered port decisions over valid/ready.
module route_select
    import route_select_pkg::*;
#(
    parameter int DIR_W = 4,
    parameter int MCAST = 0,
    localparam int IDX_W = idx_width(DIR_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DIR_W-1:0] in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_core,
    output logic [IDX_W-1:0] out_port,
    output logic             out_last,
    output logic             busy
);

    typedef struct packed {
        logic             core;
        logic [IDX_W-1:0] port;
        logic             last;
    } decision_t;

    state_t           state_reg;
    decision_t        dec_reg;
    decision_t        dec_next;
    logic [DIR_W-1:0] mask_q;
    logic [DIR_W-1:0] mask_next;

    logic             in_found, q_found, sel_found;
    logic [IDX_W-1:0] in_idx, q_idx, sel_idx;
    logic [DIR_W-1:0] in_res, q_res, sel_res;
    logic             accept, fire, advance;

    lsb_find #(.DIR_W(DIR_W)) u_in_find (
        .mask     (in_mask),
        .found    (in_found),
        .idx      (in_idx),
        .residual (in_res)
    );

    lsb_find #(.DIR_W(DIR_W)) u_q_find (
        .mask     (mask_q),
        .found    (q_found),
        .idx      (q_idx),
        .residual (q_res)
    );

    assign out_valid = (state_reg == S_EMIT);
    assign busy      = out_valid;
    assign out_core  = dec_reg.core;
    assign out_port  = dec_reg.port;
    assign out_last  = dec_reg.last;

    assign in_ready  = !out_valid || (out_ready && dec_reg.last);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    // Mid-packet advance consumes the stored residual instead of a new mask.
    assign advance   = fire && !dec_reg.last;

    assign sel_found = advance ? q_found : in_found;
    assign sel_idx   = advance ? q_idx   : in_idx;
    assign sel_res   = advance ? q_res   : in_res;

    always_comb begin
        dec_next.core = !sel_found;
        dec_next.port = sel_found ? sel_idx : '0;
        dec_next.last = (MCAST != 0) ? (sel_res == '0) : 1'b1;
        mask_next     = (MCAST != 0) ? sel_res : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            dec_reg   <= '0;
            mask_q    <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        dec_reg   <= dec_next;
                        mask_q    <= mask_next;
                        state_reg <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (fire) begin
                        if (advance || accept) begin
                            dec_reg <= dec_next;
                            mask_q  <= mask_next;
                        end else begin
                            mask_q    <= '0;
                            state_reg <= S_IDLE;
                        end
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_route_select.sv
// Bench for route_select: three configurations driven by one stimulus stream,
// one observed at a time against a queue-based model of the decision rule.
module tb_route_select;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] in_mask;
    logic       out_ready;

    logic       rdy0, val0, core0, last0, busy0;
    logic [1:0] port0;
    logic       rdy1, val1, core1, last1, busy1;
    logic [1:0] port1;
    logic       rdy2, val2, core2, last2, busy2;
    logic [2:0] port2;

    logic       o_ready, o_valid, o_core, o_last, o_busy;
    logic [2:0] o_port;

    int sel;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit core;
        int port;
        bit last;
    } dec_t;
    dec_t q[$];

    always #5 clk = ~clk;

    route_select #(.DIR_W(4), .MCAST(0)) u_uni4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
        .in_mask(in_mask[3:0]), .out_valid(val0), .out_ready(out_ready),
        .out_core(core0), .out_port(port0), .out_last(last0), .busy(busy0)
    );

    route_select #(.DIR_W(4), .MCAST(1)) u_mc4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
        .in_mask(in_mask[3:0]), .out_valid(val1), .out_ready(out_ready),
        .out_core(core1), .out_port(port1), .out_last(last1), .busy(busy1)
    );

    route_select #(.DIR_W(5), .MCAST(1)) u_mc5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .in_mask(in_mask), .out_valid(val2), .out_ready(out_ready),
        .out_core(core2), .out_port(port2), .out_last(last2), .busy(busy2)
    );

    always_comb begin
        case (sel)
            1: begin
                o_ready = rdy1; o_valid = val1; o_core = core1;
                o_port = {1'b0, port1}; o_last = last1; o_busy = busy1;
            end
            2: begin
                o_ready = rdy2; o_valid = val2; o_core = core2;
                o_port = port2; o_last = last2; o_busy = busy2;
            end
            default: begin
                o_ready = rdy0; o_valid = val0; o_core = core0;
                o_port = {1'b0, port0}; o_last = last0; o_busy = busy0;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected decisions for one packet, straight from the routing rule.
    task automatic push_packet(input logic [4:0] m);
        int dw;
        int mm;
        int hi;
        bit mc;
        dw = (sel == 2) ? 5 : 4;
        mc = (sel != 0);
        mm = int'(m) & ((1 << dw) - 1);
        if (mm == 0) begin
            q.push_back('{core: 1'b1, port: 0, last: 1'b1});
            return;
        end
        hi = 0;
        for (int i = 0; i < dw; i++) if (mm[i]) hi = i;
        for (int i = 0; i < dw; i++) begin
            if (mm[i]) begin
                if (!mc) begin
                    q.push_back('{core: 1'b0, port: i, last: 1'b1});
                    return;
                end
                q.push_back('{core: 1'b0, port: i, last: (i == hi)});
            end
        end
    endtask

    // One clock cycle: drive, check the observed DUT against the model, advance the model.
    task automatic step(input logic iv, input logic [4:0] m, input logic ordy);
        bit exp_valid, exp_rdy;
        int dw;
        dw = (sel == 2) ? 5 : 4;
        @(negedge clk);
        in_valid = iv;
        in_mask = m;
        out_ready = ordy;
        #1;
        exp_valid = (q.size() != 0);
        exp_rdy = !exp_valid || (ordy && q[0].last);
        chk("out_valid", 32'(o_valid), 32'(exp_valid));
        chk("busy", 32'(o_busy), 32'(exp_valid));
        chk("in_ready", 32'(o_ready), 32'(exp_rdy));
        chk("port_range", 32'(int'(o_port) < dw), 32'd1);
        if (exp_valid) begin
            chk("out_core", 32'(o_core), 32'(q[0].core));
            chk("out_port", 32'(o_port), 32'(q[0].port));
            chk("out_last", 32'(o_last), 32'(q[0].last));
        end
        @(posedge clk);
        if (exp_valid && ordy) void'(q.pop_front());
        if (iv && exp_rdy) push_packet(m);
    endtask

    task automatic check_reset_values();
        chk("rst_out_valid", 32'(o_valid), 32'd0);
        chk("rst_out_core", 32'(o_core), 32'd0);
        chk("rst_out_port", 32'(o_port), 32'd0);
        chk("rst_out_last", 32'(o_last), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
    endtask

    // Asynchronous pulse mid-cycle; any packet in flight is abandoned.
    task automatic pulse_reset();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        sel = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_mask = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;

        // Unicast: core delivery, then two packets back-to-back.
        step(1'b1, 5'b00000, 1'b1);
        step(1'b1, 5'b01010, 1'b1);
        step(1'b1, 5'b01000, 1'b1);
        step(1'b0, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 1'b1);

        // Multicast 1101: ports 0,2,3 with in_ready low until the last beat.
        sel = 1;
        pulse_reset();
        step(1'b1, 5'b01101, 1'b1);
        step(1'b1, 5'b00011, 1'b1);
        step(1'b1, 5'b00101, 1'b1);
        step(1'b0, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 1'b1);

        // Multicast 0110 with a 3-cycle stall and a changing, ignored mask.
        pulse_reset();
        step(1'b1, 5'b00110, 1'b1);
        step(1'b1, 5'b00001, 1'b0);
        step(1'b1, 5'b01111, 1'b0);
        step(1'b1, 5'b00100, 1'b0);
        step(1'b1, 5'b01001, 1'b1);
        step(1'b1, 5'b01001, 1'b1);
        step(1'b0, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 1'b1);

        // Five ports, reset after the first beat: port 4 must never appear.
        sel = 2;
        pulse_reset();
        step(1'b1, 5'b10001, 1'b1);
        step(1'b0, 5'b00000, 1'b1);
        pulse_reset();
        step(1'b0, 5'b00000, 1'b1);
        step(1'b0, 5'b00000, 1'b1);

        // Random traffic on every configuration.
        for (int s = 0; s < 3; s++) begin
            sel = s;
            pulse_reset();
            for (int n = 0; n < 400; n++) begin
                step($urandom_range(0, 9) < 7, 5'($urandom), $urandom_range(0, 9) < 6);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
